mem_align_unit: RTL

Parametrised, sequencing load/store alignment unit between the MEM pipeline stage and a single-port synchronous data memory without byte enables. It accepts one request at a time, extracts and extends sub-word load data, and performs sub-word stores as internal read-modify-write. Misaligned and unsupported accesses are reported as errors without touching memory. Data width is selectable (32 or 64), and a valid/ready request/response handshake provides stalling.

---
 rtl/mem_align_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_align_unit.sv
// Load/store alignment unit between the MEM stage and a word-wide synchronous
// memory without byte enables; sub-word stores are done as read-modify-write.
module mem_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    resp_err,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP,
    S_ERR_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic                resp_err_q;

  // Request decode, evaluated on the live inputs while IDLE.
  logic [2:0] req_off3;
  logic [2:0] align_mask;
  logic       req_err;
  logic       req_full;

  always_comb begin
    req_off3 = 3'(req_addr[OFF_W-1:0]);
    case (req_size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    req_err  = (|(req_off3 & align_mask)) || ((req_size == 2'd3) && (DATA_W == 32));
    req_full = (req_size == 2'(OFF_W));
  end

  // Lane extraction and merge, driven by the latched request.
  logic [OFF_W+2:0]  shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lane_mask;
  logic              sign_bit;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] wr_mask;
  logic [DATA_W-1:0] merged;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    shamt     = {addr_q[OFF_W-1:0], 3'b000};
    shifted   = mem_rdata >> shamt;
    lane_mask = '0;
    sign_bit  = 1'b0;
    case (size_q)
      2'd0: begin
        lane_mask[7:0] = '1;
        sign_bit       = shifted[7];
      end
      2'd1: begin
        lane_mask[15:0] = '1;
        sign_bit        = shifted[15];
      end
      2'd2: begin
        lane_mask[31:0] = '1;
        sign_bit        = shifted[31];
      end
      default: begin
        lane_mask = '1;
        sign_bit  = shifted[DATA_W-1];
      end
    endcase
    // A full-width lane leaves no bits to extend, so req_unsigned drops out.
    load_ext = (shifted & lane_mask) | ((sign_bit && !uns_q) ? ~lane_mask : '0);
    wr_mask  = lane_mask << shamt;
    merged   = (mem_rdata & ~wr_mask) | ((wdata_q & lane_mask) << shamt);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                state_d = S_ERR_RESP;
          else if (req_we && req_full) state_d = S_WR;
          else                        state_d = S_RD;
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: state_d = we_q ? S_WR : S_RESP;
      S_WR:  state_d = S_RESP;
      S_RESP, S_ERR_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            resp_data_q <= '0;
            resp_err_q  <= req_err;
          end
        end
        S_CAP: begin
          if (we_q) wdata_q     <= merged;
          else      resp_data_q <= load_ext;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP) || (state_q == S_ERR_RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  // Strobes are gated by rst so a write in flight cannot land during reset.
  assign mem_en     = ((state_q == S_RD) || (state_q == S_WR)) && !rst;
  assign mem_we     = (state_q == S_WR) && !rst;
  assign mem_addr   = addr_q[ADDR_W-1:OFF_W];
  assign mem_wdata  = wdata_q;

endmodule
